// File: rtl/linked_fifo_sched.sv
// Scheduler in front of a shared linked-list FIFO: accepts tagged writes, tracks
// per-queue occupancy and pops queues round-robin into a 2-entry output buffer.
module linked_fifo_sched #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int FIFOS      = 8,
  parameter int LOG2_FIFOS = $clog2(FIFOS),
  parameter int LOG2_DEPTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [LOG2_FIFOS-1:0] in_fifo,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [LOG2_FIFOS-1:0] out_fifo,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic                  lf_rst,
  output logic                  lf_push,
  output logic [LOG2_FIFOS-1:0] lf_push_fifo,
  output logic [WIDTH-1:0]      lf_d,
  output logic                  lf_pop,
  output logic [LOG2_FIFOS-1:0] lf_pop_fifo,
  input  logic [WIDTH-1:0]      lf_q,
  input  logic                  lf_full,
  output logic [FIFOS-1:0]      nonempty
);

  localparam int CW = LOG2_DEPTH + 1;
  localparam int IW = $clog2(DEPTH + 3);

  typedef enum logic {INIT, STEADY} state_t;

  state_t                state, state_next;
  logic [IW-1:0]         init_cnt;
  logic [CW-1:0]         count [FIFOS];
  logic [LOG2_FIFOS-1:0] rr_ptr, sel_fifo, rr_next;
  logic                  sel_found, room, drain, steady, wpos;
  logic [2:0]            occ;
  logic [1:0]            wtmp;
  int unsigned           idx;
  logic                  inflight;
  logic [LOG2_FIFOS-1:0] inflight_fifo;
  logic [WIDTH-1:0]      buf_data [2];
  logic [LOG2_FIFOS-1:0] buf_fifo [2];
  logic [1:0]            buf_cnt;

  assign lf_rst = ~rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) init_cnt <= init_cnt + IW'(1);
    end
  end

  always_comb begin
    state_next = state;
    if (state == INIT && init_cnt == IW'(DEPTH + 1)) state_next = STEADY;
  end

  always_comb begin
    steady       = (state == STEADY);
    in_ready     = steady & ~lf_full;
    lf_push      = in_valid & in_ready;
    lf_push_fifo = in_fifo;
    lf_d         = in_data;
    out_valid    = (buf_cnt != 2'd0);
    out_data     = buf_data[0];
    out_fifo     = buf_fifo[0];
    drain        = out_valid & out_ready;
    // Buffered + in-flight words, less the one leaving this cycle, must stay below 2.
    occ          = {1'b0, buf_cnt} + {2'b00, inflight};
    room         = (occ < 3'd2) || (drain && occ == 3'd2);
    lf_pop       = steady & sel_found & room;
    lf_pop_fifo  = sel_fifo;
    wtmp         = buf_cnt - {1'b0, drain};
    wpos         = wtmp[0];
    for (int unsigned i = 0; i < FIFOS; i++) nonempty[i] = (count[i] != '0);
  end

  // Round-robin search over registered counts only, starting at rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_fifo  = '0;
    idx       = 0;
    for (int unsigned i = 0; i < FIFOS; i++) begin
      idx = (32'(rr_ptr) + i) % FIFOS;
      if (!sel_found && count[idx] != '0) begin
        sel_found = 1'b1;
        sel_fifo  = LOG2_FIFOS'(idx);
      end
    end
    rr_next = (sel_fifo == LOG2_FIFOS'(FIFOS - 1)) ? '0 : sel_fifo + LOG2_FIFOS'(1);
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < FIFOS; i++) begin
      if (!rst) count[i] <= '0;
      else count[i] <= count[i]
                     + CW'(lf_push && lf_push_fifo == LOG2_FIFOS'(i))
                     - CW'(lf_pop && lf_pop_fifo == LOG2_FIFOS'(i));
    end
  end

  // lf_q is valid the cycle after a pop; a same-cycle dequeue shifts the head first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight      <= 1'b0;
      inflight_fifo <= '0;
      rr_ptr        <= '0;
      buf_cnt       <= 2'd0;
      buf_data[0]   <= '0;
      buf_data[1]   <= '0;
      buf_fifo[0]   <= '0;
      buf_fifo[1]   <= '0;
    end else begin
      inflight      <= lf_pop;
      inflight_fifo <= sel_fifo;
      if (lf_pop) rr_ptr <= rr_next;
      if (drain) begin
        buf_data[0] <= buf_data[1];
        buf_fifo[0] <= buf_fifo[1];
      end
      if (inflight) begin
        buf_data[wpos] <= lf_q;
        buf_fifo[wpos] <= inflight_fifo;
      end
      buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, drain};
    end
  end

endmodule

// File: doc/linked_fifo_sched.md
LINKED_FIFO_SCHED -- requirements
Module: linked_fifo_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width.
REQ-002 SHALL have parameter DEPTH, default 32: shared linked-FIFO entries.
REQ-003 SHALL have parameter FIFOS, default 8: number of logical queues.
REQ-004 SHALL have parameter LOG2_FIFOS, default log2(FIFOS-1): queue index width.
REQ-005 SHALL have parameter LOG2_DEPTH, default log2(DEPTH-1): entry index width.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on posedge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-low reset (asserted when 0).
REQ-008 SHALL have port in_valid, input, 1: write request.
REQ-009 SHALL have port in_fifo, input, LOG2_FIFOS: target queue of the write.
REQ-010 SHALL have port in_data, input, WIDTH: write data.
REQ-011 SHALL have port in_ready, output, 1: write accepted when in_valid & in_ready.
REQ-012 SHALL have port out_valid, output, 1: out_data/out_fifo valid.
REQ-013 SHALL have port out_fifo, output, LOG2_FIFOS: source queue of out_data.
REQ-014 SHALL have port out_data, output, WIDTH: read data.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts when out_valid & out_ready.
REQ-016 SHALL have port lf_rst, output, 1: active-high reset to the shared linked FIFO.
REQ-017 SHALL have ports lf_push (output, 1), lf_push_fifo (output, LOG2_FIFOS), lf_d (output, WIDTH), lf_pop (output, 1) and lf_pop_fifo (output, LOG2_FIFOS): linked-FIFO command bus.
REQ-018 SHALL have ports lf_q (input, WIDTH) and lf_full (input, 1): linked-FIFO read data and free-list-exhausted flag.
REQ-019 SHALL have port nonempty, output, FIFOS: bit i high when queue i count > 0.

Function
REQ-020 SHALL drive lf_rst = ~rst combinationally.
REQ-021 SHALL implement states INIT and STEADY; INIT → STEADY after DEPTH+2 cycles with rst high, counted by an init counter; no other transitions except reset.
REQ-022 In INIT, SHALL hold in_ready=0, out_valid=0, lf_push=0 and lf_pop=0.
REQ-023 In STEADY, in_ready SHALL equal ~lf_full.
REQ-024 On an accepted write, SHALL assert lf_push with lf_push_fifo=in_fifo and lf_d=in_data in the same cycle (combinational pass-through), and increment count[in_fifo].
REQ-025 SHALL keep one count per queue, LOG2_DEPTH+1 bits wide, never wrapping; a write to a queue when lf_full=1 is impossible because of REQ-023.
REQ-026 Pop eligibility SHALL use registered counts only, so a queue written this cycle is not poppable until the next cycle.
REQ-027 Pop selection SHALL be round-robin: the first queue with count>0 at or after rr_ptr, modulo FIFOS; after a pop of queue k, rr_ptr ← (k+1) mod FIFOS.
REQ-028 SHALL use a 2-entry output buffer; a pop SHALL issue only when buffered entries + in-flight pops − (out_valid & out_ready) < 2.
REQ-029 lf_q SHALL be captured into the buffer exactly 1 cycle after lf_pop, tagged with the popped queue index; this gives a read latency of 2 cycles from pop to out_valid when the buffer is empty.
REQ-030 Sustained throughput SHALL be one word per cycle when out_ready=1 and some queue is nonempty.
REQ-031 Simultaneous push and pop SHALL be permitted, including to the same queue; that queue's count is then unchanged.
REQ-032 The buffer SHALL present data in FIFO order; out_data and out_fifo SHALL stay stable while out_valid & ~out_ready.
REQ-033 A pop SHALL decrement count[lf_pop_fifo] in the cycle it issues.

Reset
REQ-034 While rst=0, SHALL clear all counts, rr_ptr, buffer and in-flight state, and the init counter, and SHALL enter INIT; outputs SHALL be in_ready=0, out_valid=0, lf_push=0, lf_pop=0, nonempty=0 and lf_rst=1.
REQ-035 Reset asserted mid-operation SHALL discard buffered and in-flight data; a capture due the cycle after reset SHALL be dropped.

Verification
REQ-036 Reset, then idle -> in_ready rises exactly DEPTH+2 cycles after rst goes high; no lf_push or lf_pop before that.
REQ-037 Write 0x11, 0x22 to queue 3 with out_ready=1 -> out 0x11 then 0x22, both with out_fifo=3, the first 2 cycles after its pop; nonempty[3] ends at 0.
REQ-038 Load queues 0, 2 and 5 with one word each, then raise out_ready -> out_fifo order is 0, 2, 5; with rr_ptr=3 at start, the order is 5, 0, 2.
REQ-039 Write DEPTH−FIFOS=24 words with out_ready=0 -> lf_full=1 and in_ready=0; the 25th write is not accepted; pops stop after the 2 buffer entries fill.
REQ-040 Hold out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_fifo stable; then release -> no loss or duplication.
REQ-041 Assert rst=0 for 1 cycle with 2 words buffered -> out_valid=0 next cycle; the FSM re-enters INIT.
